// File: rtl/ecg_pkg.sv
// Shared constants for the ECG trace RAM. The display reader uses the same
// base address and screen width, so both sides agree on the layout.
package ecg_pkg;
    localparam int ECG_W      = 12;
    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DATA_W = 32;
    localparam int SCREEN_W   = 640;
    localparam int COL_W      = 10;
    localparam logic [RAM_ADDR_W-1:0] ECG_BASE_ADDR = 12'h801;

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_WR     = 2'd1,
        ST_FROZEN = 2'd2
    } ecg_state_t;
endpackage

// File: rtl/ecg_trace_writer_if.sv
// Sample stream in, RAM write port out. The slave modport is the writer's
// view; the master side feeds samples and watches RAM writes.
interface ecg_trace_writer_if;
    import ecg_pkg::*;

    logic                  s_valid;
    logic                  s_ready;
    logic [ECG_W-1:0]      s_data;
    logic                  ram_we;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [RAM_DATA_W-1:0] ram_wdata;

    modport slave  (input  s_valid, s_data,
                    output s_ready, ram_we, ram_addr, ram_wdata);
    modport master (output s_valid, s_data,
                    input  s_ready, ram_we, ram_addr, ram_wdata);
endinterface

// File: rtl/ecg_decimator.sv
// Block averager: sums DECIM samples and flags the last one, presenting the
// truncated average of the completed block in the same cycle.
module ecg_decimator
    import ecg_pkg::*;
#(
    parameter int DECIM = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             acc_en_i,
    input  logic [ECG_W-1:0] data_i,
    output logic             done_o,
    output logic [ECG_W-1:0] avg_o
);
    localparam int SHIFT = $clog2(DECIM);
    localparam int SUM_W = ECG_W + SHIFT;
    localparam int CNT_W = 7;

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;

    function automatic logic [ECG_W-1:0] trunc_avg(input logic [SUM_W-1:0] s);
        return ECG_W'(s >> SHIFT);
    endfunction

    assign last   = (cnt_q == CNT_W'(DECIM - 1));
    assign done_o = acc_en_i && last;
    assign sum_d  = sum_q + SUM_W'(data_i);
    assign cnt_d  = last ? '0 : cnt_q + CNT_W'(1);
    // Average includes the sample arriving now, so the write data is ready
    // to register on the same edge that completes the block.
    assign avg_o  = trunc_avg(sum_d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else if (acc_en_i) begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ecg_trace_writer.sv
// Decimates the ECG sample stream and writes one averaged sample per screen
// column into a circular RAM region, with frame-aligned freeze of the trace.
module ecg_trace_writer
    import ecg_pkg::*;
#(
    parameter logic [RAM_ADDR_W-1:0] BASE_ADDR = ECG_BASE_ADDR,
    parameter int                    DEPTH     = SCREEN_W,
    parameter int                    DECIM     = 4
) (
    input  logic               clock,
    input  logic               reset,
    ecg_trace_writer_if.slave  bus,
    input  logic               frame_end,
    input  logic               freeze,
    output logic [COL_W-1:0]   col,
    output logic               wrapped,
    output logic               frozen
);
    ecg_state_t            state_q, state_d;
    logic                  ready_q, we_q, wrapped_q;
    logic [RAM_ADDR_W-1:0] addr_q;
    logic [ECG_W-1:0]      wdata_q;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  freeze_hit, resume_hit, acc_en, dec_clr, dec_done, col_last;
    logic [ECG_W-1:0]      dec_avg;

    assign freeze_hit = frame_end && freeze;
    assign resume_hit = frame_end && !freeze;
    // A freeze request in ACC wins over a block that would complete this cycle.
    assign acc_en     = (state_q == ST_ACC) && ready_q && bus.s_valid && !freeze_hit;
    assign col_last   = (col_q == COL_W'(DEPTH - 1));

    ecg_decimator #(.DECIM(DECIM)) u_decim (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (dec_clr),
        .acc_en_i (acc_en),
        .data_i   (bus.s_data),
        .done_o   (dec_done),
        .avg_o    (dec_avg)
    );

    always_comb begin
        state_d = state_q;
        dec_clr = 1'b0;
        col_d   = col_q;
        case (state_q)
            ST_ACC: begin
                if (freeze_hit) begin
                    state_d = ST_FROZEN;
                    dec_clr = 1'b1;
                end else if (dec_done) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                dec_clr = 1'b1;
                col_d   = col_last ? '0 : col_q + COL_W'(1);
                state_d = freeze_hit ? ST_FROZEN : ST_ACC;
            end
            ST_FROZEN: begin
                dec_clr = 1'b1;
                if (resume_hit) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ACC;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            col_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d != ST_WR);
            we_q      <= dec_done;
            if (dec_done) begin
                addr_q  <= BASE_ADDR + RAM_ADDR_W'(col_q);
                wdata_q <= dec_avg;
            end
            col_q     <= col_d;
            wrapped_q <= (state_q == ST_WR) && col_last;
        end
    end

    assign bus.s_ready   = ready_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = {{(RAM_DATA_W - ECG_W){1'b0}}, wdata_q};
    assign col           = col_q;
    assign wrapped       = wrapped_q;
    assign frozen        = (state_q == ST_FROZEN);
endmodule

// File: tb/tb_ecg_trace_writer.sv
// Bench for ecg_trace_writer: a DECIM=4 instance against a block-average
// reference model, and a DECIM=1 instance for the streaming case.
module tb_ecg_trace_writer;
    import ecg_pkg::*;

    localparam int               DECIM = 4;
    localparam int               DEPTH = 640;
    localparam logic [11:0]      BASE  = 12'h801;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       fe4 = 1'b0, fz4 = 1'b0, fe1 = 1'b0, fz1 = 1'b0;
    logic [9:0] col4, col1;
    logic       wr4, wr1, fr4, fr1;

    ecg_trace_writer_if bus4 ();
    ecg_trace_writer_if bus1 ();

    ecg_trace_writer #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DECIM(DECIM)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4), .frame_end(fe4), .freeze(fz4),
        .col(col4), .wrapped(wr4), .frozen(fr4));

    ecg_trace_writer #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DECIM(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1), .frame_end(fe1), .freeze(fz1),
        .col(col1), .wrapped(wr1), .frozen(fr1));

    int tests = 0;
    int fails = 0;

    // Reference model: trace behaviour in terms of sample blocks and columns.
    int          m_col;
    bit          m_wr, m_frozen, m_wrap, m_boot;
    logic [11:0] m_addr, m_data;
    int          m_blk[$];

    // {ready, we, addr[11:0], wdata[31:0], col[9:0], wrapped, frozen}
    logic [57:0] obs_v, exp_v;

    task automatic model_reset();
        m_col = 0; m_wr = 0; m_frozen = 0; m_wrap = 0; m_boot = 1;
        m_addr = '0; m_data = '0;
        m_blk.delete();
    endtask

    task automatic step(input bit v, input logic [11:0] d, input bit fe, input bit fz);
        bit nxt_wrap;
        int s;
        bus4.s_valid = v; bus4.s_data = d; fe4 = fe; fz4 = fz;
        @(negedge clock);
        obs_v = {bus4.s_ready, bus4.ram_we, bus4.ram_addr, bus4.ram_wdata, col4, wr4, fr4};
        exp_v = {~m_wr & ~m_boot, m_wr, m_addr, {20'd0, m_data}, 10'(m_col), m_wrap, m_frozen};
        nxt_wrap = 0;
        if (m_frozen) begin
            if (fe && !fz) m_frozen = 0;
        end else if (m_wr) begin
            m_wr     = 0;
            nxt_wrap = (m_col == DEPTH - 1);
            m_col    = (m_col + 1) % DEPTH;
            if (fe && fz) m_frozen = 1;
        end else if (fe && fz) begin
            m_frozen = 1;
            m_blk.delete();
        end else if (v && !m_boot) begin
            m_blk.push_back(int'(d));
            if (m_blk.size() == DECIM) begin
                s = 0;
                foreach (m_blk[i]) s += m_blk[i];
                m_addr = BASE + 12'(m_col);
                m_data = 12'(s / DECIM);
                m_blk.delete();
                m_wr = 1;
            end
        end
        m_wrap = nxt_wrap;
        m_boot = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        tests++; if (bus4.s_ready !== 1'b0) begin fails++; $display("FAIL %s_ready got=%b exp=0", tag, bus4.s_ready); end
        tests++; if (bus4.ram_we !== 1'b0) begin fails++; $display("FAIL %s_we got=%b exp=0", tag, bus4.ram_we); end
        tests++; if (bus4.ram_addr !== 12'h000) begin fails++; $display("FAIL %s_addr got=%h exp=000", tag, bus4.ram_addr); end
        tests++; if (bus4.ram_wdata !== 32'd0) begin fails++; $display("FAIL %s_wdata got=%h exp=0", tag, bus4.ram_wdata); end
        tests++; if (col4 !== 10'd0) begin fails++; $display("FAIL %s_col got=%0d exp=0", tag, col4); end
        tests++; if ({wr4, fr4} !== 2'b00) begin fails++; $display("FAIL %s_wrap_frozen got=%b exp=00", tag, {wr4, fr4}); end
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge clock);
        #1;
        apply_reset("reset");
        for (int i = 0; i < 2; i++) begin
            step(0, 12'd0, 0, 0);
            tests++; if (obs_v !== exp_v) begin fails++; $display("FAIL reset_release cyc%0d got=%h exp=%h", i, obs_v, exp_v); end
        end
        tests++; if (obs_v[57] !== 1'b1) begin fails++; $display("FAIL reset_ready_up got=%b exp=1", obs_v[57]); end
    endtask

    task automatic test_single();
        logic [11:0] d [6];
        d = '{12'd100, 12'd200, 12'd300, 12'd400, 12'd0, 12'd0};
        for (int i = 0; i < 6; i++) begin
            step(i < 4, d[i], 0, 0);
            tests++; if (obs_v !== exp_v) begin fails++; $display("FAIL single cyc%0d got=%h exp=%h", i, obs_v, exp_v); end
            if (i == 4) begin
                tests++;
                if (obs_v !== {1'b0, 1'b1, 12'h801, 32'd250, 10'd0, 1'b0, 1'b0}) begin
                    fails++; $display("FAIL single_write got=%h exp=%h", obs_v, {1'b0, 1'b1, 12'h801, 32'd250, 10'd0, 2'b00});
                end
            end
            if (i == 5) begin
                tests++;
                if (obs_v !== {1'b1, 1'b0, 12'h801, 32'd250, 10'd1, 1'b0, 1'b0}) begin
                    fails++; $display("FAIL single_after got=%h exp=%h", obs_v, {1'b1, 1'b0, 12'h801, 32'd250, 10'd1, 2'b00});
                end
            end
        end
    endtask

    task automatic test_wrap();
        int nw = 0;
        int nwrap = 0;
        apply_reset("wrap_rst");
        step(0, 12'd0, 0, 0);
        for (int k = 0; k < 3400 && nw < 641; k++) begin
            step(1, 12'd2048, 0, 0);
            tests++; if (obs_v !== exp_v) begin fails++; $display("FAIL wrap_model cyc%0d got=%h exp=%h", k, obs_v, exp_v); end
            if (obs_v[1]) begin
                nwrap++;
                tests++;
                if (obs_v[11:2] !== 10'd0 || nw != 640) begin
                    fails++; $display("FAIL wrap_pulse col=%0d writes=%0d exp col=0 writes=640", obs_v[11:2], nw);
                end
            end
            if (obs_v[56]) begin
                tests++;
                if (obs_v[55:44] !== 12'h801 + 12'(nw % 640) || obs_v[43:12] !== 32'd2048) begin
                    fails++; $display("FAIL wrap_write n=%0d addr=%h data=%0d exp addr=%h data=2048",
                                      nw, obs_v[55:44], obs_v[43:12], 12'h801 + 12'(nw % 640));
                end
                nw++;
            end
        end
        tests++; if (nwrap != 1) begin fails++; $display("FAIL wrap_count got=%0d exp=1", nwrap); end
        tests++; if (nw != 641) begin fails++; $display("FAIL wrap_budget writes=%0d exp=641", nw); end
    endtask

    task automatic test_freeze_mid();
        logic [14:0] tab [14];
        tab = '{{1'b1, 12'd10, 2'b00}, {1'b1, 12'd20, 2'b00}, {1'b0, 12'd0, 2'b11},
                {1'b1, 12'd5, 2'b01}, {1'b1, 12'd6, 2'b01}, {1'b1, 12'd7, 2'b01},
                {1'b1, 12'd8, 2'b01}, {1'b1, 12'd9, 2'b01}, {1'b0, 12'd0, 2'b10},
                {1'b1, 12'd1000, 2'b00}, {1'b1, 12'd1001, 2'b00}, {1'b1, 12'd1002, 2'b00},
                {1'b1, 12'd1003, 2'b00}, {1'b0, 12'd0, 2'b00}};
        step(0, 12'd0, 0, 0);
        step(0, 12'd0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(tab[i][14], tab[i][13:2], tab[i][1], tab[i][0]);
            tests++; if (obs_v !== exp_v) begin fails++; $display("FAIL freeze_mid cyc%0d got=%h exp=%h", i, obs_v, exp_v); end
            if (i >= 3 && i <= 8) begin
                tests++;
                if ({obs_v[57], obs_v[56], obs_v[0]} !== 3'b101) begin
                    fails++; $display("FAIL freeze_hold cyc%0d ready/we/frozen=%b exp=101", i, {obs_v[57], obs_v[56], obs_v[0]});
                end
            end
            if (i == 9) begin
                tests++; if (obs_v[0] !== 1'b0) begin fails++; $display("FAIL freeze_exit frozen=%b exp=0", obs_v[0]); end
            end
            if (i == 13) begin
                tests++;
                if (obs_v[56:12] !== {1'b1, 12'h802, 32'd1001}) begin
                    fails++; $display("FAIL freeze_resume_write got=%h exp=%h", obs_v[56:12], {1'b1, 12'h802, 32'd1001});
                end
            end
        end
    endtask

    task automatic test_freeze_wr();
        logic [14:0] tab [10];
        tab = '{{1'b1, 12'd7, 2'b00}, {1'b1, 12'd8, 2'b00}, {1'b1, 12'd9, 2'b00},
                {1'b1, 12'd10, 2'b00}, {1'b0, 12'd0, 2'b11}, {1'b1, 12'd50, 2'b01},
                {1'b1, 12'd60, 2'b00}, {1'b0, 12'd0, 2'b00}, {1'b0, 12'd0, 2'b10},
                {1'b0, 12'd0, 2'b00}};
        for (int i = 0; i < 10; i++) begin
            step(tab[i][14], tab[i][13:2], tab[i][1], tab[i][0]);
            tests++; if (obs_v !== exp_v) begin fails++; $display("FAIL freeze_wr cyc%0d got=%h exp=%h", i, obs_v, exp_v); end
            if (i == 4) begin
                tests++;
                if ({obs_v[56:12], obs_v[0]} !== {1'b1, 12'h803, 32'd8, 1'b0}) begin
                    fails++; $display("FAIL freeze_wr_write got=%h exp=%h", {obs_v[56:12], obs_v[0]}, {1'b1, 12'h803, 32'd8, 1'b0});
                end
            end
            if (i == 5) begin
                tests++;
                if ({obs_v[56], obs_v[0], obs_v[11:2]} !== {1'b0, 1'b1, 10'd3}) begin
                    fails++; $display("FAIL freeze_wr_after we/frozen/col=%b/%b/%0d exp 0/1/3", obs_v[56], obs_v[0], obs_v[11:2]);
                end
            end
        end
    endtask

    task automatic test_random();
        int nw = 0;
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 3) != 0, 12'($urandom_range(0, 4095)),
                 $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)));
            tests++; if (obs_v !== exp_v) begin fails++; $display("FAIL random cyc%0d got=%h exp=%h", k, obs_v, exp_v); end
            if (obs_v[56]) nw++;
        end
        tests++; if (nw < 20) begin fails++; $display("FAIL random_activity writes=%0d exp>=20", nw); end
    endtask

    task automatic test_reset_wr();
        bit hit = 0;
        step(0, 12'd0, 1, 0);
        tests++; if (obs_v !== exp_v) begin fails++; $display("FAIL rstwr_unfreeze got=%h exp=%h", obs_v, exp_v); end
        fe4 = 0; fz4 = 0;
        for (int k = 0; k < 12 && !hit; k++) begin
            bus4.s_valid = 1; bus4.s_data = 12'($urandom_range(0, 4095));
            @(negedge clock);
            if (bus4.ram_we === 1'b1) hit = 1;
            else begin @(posedge clock); #1; end
        end
        tests++; if (!hit) begin fails++; $display("FAIL rstwr_reach_wr got=0 exp=1"); end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({bus4.ram_we, bus4.s_ready, col4} !== {1'b0, 1'b0, 10'd0}) begin
            fails++; $display("FAIL rstwr_async we/ready/col=%b/%b/%0d exp 0/0/0", bus4.ram_we, bus4.s_ready, col4);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step(i >= 1 && i <= 4, 12'($urandom_range(0, 4095)), 0, 0);
            tests++; if (obs_v !== exp_v) begin fails++; $display("FAIL rstwr cyc%0d got=%h exp=%h", i, obs_v, exp_v); end
        end
        tests++; if (obs_v[56:44] !== {1'b1, 12'h801}) begin fails++; $display("FAIL rstwr_first_addr got=%h exp=1801", obs_v[56:44]); end
    endtask

    task automatic test_decim1();
        int nw = 0;
        bit er, ew;
        apply_reset("d1_rst");
        bus1.s_valid = 1; bus1.s_data = 12'hFFF;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clock);
            er = (k != 0) && (k % 2 == 1);
            ew = (k != 0) && (k % 2 == 0);
            tests++;
            if ({bus1.s_ready, bus1.ram_we} !== {er, ew}) begin
                fails++; $display("FAIL d1_handshake cyc%0d ready/we=%b exp=%b", k, {bus1.s_ready, bus1.ram_we}, {er, ew});
            end
            if (bus1.ram_we === 1'b1) begin
                tests++;
                if (bus1.ram_addr !== 12'h801 + 12'(nw) || bus1.ram_wdata !== 32'd4095) begin
                    fails++; $display("FAIL d1_write n=%0d addr=%h data=%0d exp addr=%h data=4095",
                                      nw, bus1.ram_addr, bus1.ram_wdata, 12'h801 + 12'(nw));
                end
                nw++;
            end
            @(posedge clock);
            #1;
        end
        tests++;
        if (nw != 10 || col1 !== 10'd10 || fr1 !== 1'b0 || wr1 !== 1'b0) begin
            fails++; $display("FAIL d1_total writes=%0d col=%0d frozen=%b wrapped=%b exp 10/10/0/0", nw, col1, fr1, wr1);
        end
        bus1.s_valid = 0;
    endtask

    initial begin
        bus4.s_valid = 0; bus4.s_data = '0;
        bus1.s_valid = 0; bus1.s_data = '0;
        model_reset();
        test_reset();
        test_single();
        test_wrap();
        test_freeze_mid();
        test_freeze_wr();
        test_random();
        test_reset_wr();
        test_decim1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached tests=%0d", tests);
        $fatal(1, "watchdog");
    end
endmodule
